// File: rtl/fifo_rd_framer.sv
// Read-side FIFO consumer: pops bytes into a 2-entry skid buffer and emits them
// as valid/ready frames of FRAME_LEN data words plus one XOR checksum word.
`timescale 1ns/1ps
module fifo_rd_framer #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 en,
  input  logic                 empty,
  input  logic [DATA_SIZE-1:0] rdata,
  output logic                 r_en,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic                 busy
);

  localparam int unsigned BC_W = 16;
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CSUM = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           count;
  logic                 inflight;
  logic [DATA_SIZE-1:0] skid0;
  logic [DATA_SIZE-1:0] skid1;
  logic [BC_W-1:0]      byte_cnt;
  logic [DATA_SIZE-1:0] csum;
  logic                 take;
  logic                 csum_xfer;
  logic [2:0]           level;
  logic [1:0]           wr_slot;

  // take uses only registered state plus out_ready, so out_valid never sees out_ready
  assign take      = (state == DATA) && (count != 2'd0) && out_ready;
  assign csum_xfer = (state == CSUM) && out_ready;
  // occupancy after this cycle's pop and the pending write of the in-flight word
  assign level     = 3'(count) + 3'(inflight) - 3'(take);
  assign wr_slot   = count - 2'(take);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = DATA;
      DATA: if (take && (byte_cnt == LAST_IDX)) state_nxt = CSUM;
      CSUM: if (out_ready) state_nxt = en ? DATA : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      DATA: begin
        out_valid = (count != 2'd0);
        out_data  = skid0;
      end
      CSUM: begin
        out_valid = 1'b1;
        out_data  = csum;
        out_last  = 1'b1;
      end
      default: ;
    endcase
    r_en = (state != IDLE) && !empty && (level < 3'd2);
  end

  // skid buffer, pop tracking and frame accounting
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      count     <= 2'd0;
      inflight  <= 1'b0;
      skid0     <= '0;
      skid1     <= '0;
      byte_cnt  <= '0;
      csum      <= '0;
      frame_cnt <= '0;
    end else begin
      inflight <= r_en;
      count    <= 2'(level);
      if (take) begin
        skid0    <= skid1;
        csum     <= csum ^ skid0;
        byte_cnt <= (byte_cnt == LAST_IDX) ? '0 : byte_cnt + BC_W'(1);
      end
      // a simultaneous pop moves the tail slot down, so the write lands after the shift
      if (inflight) begin
        if (wr_slot == 2'd0) skid0 <= rdata;
        else                 skid1 <= rdata;
      end
      if (csum_xfer) begin
        csum      <= '0;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_framer.sv
// Bench for fifo_rd_framer: FIFO model plus a stream model that expects popped
// words in order, grouped by FRAME_LEN, each frame closed by its XOR checksum.
`timescale 1ns/1ps
module tb_fifo_rd_framer;

  localparam int unsigned FL  = 4;
  localparam int unsigned FLW = 2;
  localparam int unsigned CWW = 4;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0;
  logic        en = 1'b0;
  logic        empty;
  logic [7:0]  rdata = 8'h00;
  logic        r_en;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic [15:0] frame_cnt;
  logic        busy;

  logic        en_w = 1'b0;
  logic        empty_w = 1'b0;
  logic [7:0]  rdata_w = 8'h00;
  logic        r_en_w;
  logic [7:0]  out_data_w;
  logic        out_valid_w;
  logic        out_ready_w = 1'b0;
  logic        out_last_w;
  logic [3:0]  frame_cnt_w;
  logic        busy_w;

  always #5 rclk = ~rclk;

  fifo_rd_framer #(.DATA_SIZE(8), .FRAME_LEN(FL), .CNT_W(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .en(en), .empty(empty), .rdata(rdata),
    .r_en(r_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .frame_cnt(frame_cnt), .busy(busy)
  );

  fifo_rd_framer #(.DATA_SIZE(8), .FRAME_LEN(FLW), .CNT_W(CWW)) dut_w (
    .rclk(rclk), .rrst_n(rrst_n), .en(en_w), .empty(empty_w), .rdata(rdata_w),
    .r_en(r_en_w), .out_data(out_data_w), .out_valid(out_valid_w),
    .out_ready(out_ready_w), .out_last(out_last_w), .frame_cnt(frame_cnt_w), .busy(busy_w)
  );

  // FIFO model: words loaded by tasks, popped on r_en, data one cycle later
  logic [7:0] fmem [0:255];
  logic [7:0] pw   [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pw_wr  = 0;

  assign empty = (rd_ptr == wr_ptr);

  always @(posedge rclk) begin
    if (r_en && (rd_ptr != wr_ptr)) begin
      rdata        <= fmem[rd_ptr[7:0]];
      pw[pw_wr[7:0]] <= fmem[rd_ptr[7:0]];
      pw_wr        <= pw_wr + 1;
      rd_ptr       <= rd_ptr + 1;
    end
  end

  always @(posedge rclk) rdata_w <= rdata_w + 8'd1;

  int checks = 0;
  int errors = 0;
  int pw_rd = 0;
  int m_idx = 0;
  int exp_frames = 0;
  int data_xfers = 0;
  int w_frames = 0;
  int cap_n = 0;
  logic [7:0] m_csum = 8'h00;
  logic [7:0] capt [0:63];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  // One clock: stream model at the falling edge, then return just after the rising edge
  task automatic tick();
    @(negedge rclk);
    if (!rrst_n) begin
      pw_rd = pw_wr; m_idx = 0; m_csum = 8'h00; exp_frames = 0;
      data_xfers = 0; cap_n = 0; prev_stall = 1'b0; w_frames = 0;
    end else begin
      checks++;
      if (pw_wr - pw_rd > 2) begin
        errors++; $display("FAIL lookahead: %0d words popped ahead, limit 2", pw_wr - pw_rd);
      end
      checks++;
      if (r_en && empty) begin
        errors++; $display("FAIL pop_on_empty: r_en=1 while empty=1, required r_en=0");
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (out_valid && out_ready) begin
        if (cap_n < 64) capt[cap_n] = out_data;
        cap_n++;
        checks++;
        if (m_idx == int'(FL)) begin
          if (out_last !== 1'b1 || out_data !== m_csum) begin
            errors++;
            $display("FAIL checksum: data=%h last=%b, required data=%h last=1", out_data, out_last, m_csum);
          end
          m_idx = 0; m_csum = 8'h00; exp_frames++;
        end else if (pw_rd == pw_wr) begin
          errors++; $display("FAIL phantom_word: data=%h emitted, required no word (none popped)", out_data);
        end else begin
          if (out_last !== 1'b0 || out_data !== pw[pw_rd[7:0]]) begin
            errors++;
            $display("FAIL data_word: data=%h last=%b, required data=%h last=0",
                     out_data, out_last, pw[pw_rd[7:0]]);
          end
          m_csum = m_csum ^ pw[pw_rd[7:0]];
          pw_rd++; m_idx++; data_xfers++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (out_valid_w && out_ready_w && out_last_w) w_frames++;
    end
    @(posedge rclk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    fmem[wr_ptr[7:0]] = v;
    wr_ptr++;
  endtask

  task automatic do_reset();
    rrst_n = 1'b0; en = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rrst_n = 1'b1;
  endtask

  task automatic wait_frames(input int n, input string tag);
    for (int i = 0; i < 600 && exp_frames < n; i++) tick();
    checks++;
    if (exp_frames < n) begin
      errors++; $display("FAIL %s_timeout: frames=%0d, required %0d", tag, exp_frames, n);
    end
  endtask

  task automatic wait_xfers(input int n, input string tag);
    for (int i = 0; i < 300 && data_xfers < n; i++) tick();
    checks++;
    if (data_xfers < n) begin
      errors++; $display("FAIL %s_timeout: data words=%0d, required %0d", tag, data_xfers, n);
    end
  endtask

  task automatic check_table(input string tag);
    logic [7:0] t [10];
    t = '{8'd3, 8'd5, 8'd7, 8'd9, 8'h08, 8'd11, 8'd13, 8'd15, 8'd17, 8'h18};
    checks++;
    if (cap_n != 10) begin
      errors++; $display("FAIL %s_count: %0d words, required 10", tag, cap_n);
    end
    for (int i = 0; i < 10 && i < cap_n; i++) begin
      checks++;
      if (capt[i] !== t[i]) begin
        errors++; $display("FAIL %s_word%0d: %h, required %h", tag, i, capt[i], t[i]);
      end
    end
  endtask

  task automatic load_table();
    logic [7:0] v [8];
    v = '{8'd3, 8'd5, 8'd7, 8'd9, 8'd11, 8'd13, 8'd15, 8'd17};
    for (int i = 0; i < 8; i++) load(v[i]);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({r_en, out_valid, out_last, busy} !== 4'b0000 || out_data !== 8'h00 || frame_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: r_en=%b valid=%b last=%b busy=%b data=%h frames=%0d, required all 0",
               r_en, out_valid, out_last, busy, out_data, frame_cnt);
    end
    checks++;
    if (frame_cnt_w !== 4'h0 || busy_w !== 1'b0) begin
      errors++; $display("FAIL reset_wrap_dut: frames=%0d busy=%b, required 0/0", frame_cnt_w, busy_w);
    end
    @(posedge rclk); #1;
    tick();
    rrst_n = 1'b1;
    load(8'hA5);
    tick(); tick();
    checks++;
    if (r_en !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_no_pop: r_en=%b busy=%b with en=0, required 0/0", r_en, busy);
    end
    do_reset();
    // drain the probe word so later tests start from an empty FIFO
    en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 10 && rd_ptr != wr_ptr; i++) tick();
  endtask

  task automatic test_basic();
    do_reset();
    load_table();
    en = 1'b1; out_ready = 1'b1;
    wait_frames(2, "basic");
    checks++;
    if (frame_cnt !== 16'd2) begin
      errors++; $display("FAIL basic_frame_cnt: %0d, required 2", frame_cnt);
    end
    check_table("basic");
  endtask

  task automatic test_backpressure();
    int p0;
    do_reset();
    load_table();
    en = 1'b1; out_ready = 1'b1;
    wait_xfers(1, "bp_first");
    out_ready = 1'b0;
    p0 = rd_ptr;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd5) begin
      errors++; $display("FAIL bp_hold: valid=%b data=%h, required valid=1 data=05", out_valid, out_data);
    end
    checks++;
    if (rd_ptr - p0 > 2) begin
      errors++; $display("FAIL bp_pops: %0d pops during stall, limit 2", rd_ptr - p0);
    end
    out_ready = 1'b1;
    wait_frames(2, "bp");
    check_table("bp");
  endtask

  task automatic test_underflow();
    do_reset();
    load(8'($urandom)); load(8'($urandom));
    en = 1'b1; out_ready = 1'b1;
    wait_xfers(2, "uf_first");
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_valid !== 1'b0 || r_en !== 1'b0) begin
        errors++; $display("FAIL uf_gap%0d: valid=%b r_en=%b, required 0/0", i, out_valid, r_en);
      end
      tick();
    end
    load(8'($urandom)); load(8'($urandom));
    wait_frames(1, "uf");
    checks++;
    if (frame_cnt !== 16'd1 || data_xfers != 4) begin
      errors++; $display("FAIL uf_done: frames=%0d words=%0d, required 1/4", frame_cnt, data_xfers);
    end
  endtask

  task automatic test_en_drop();
    do_reset();
    for (int i = 0; i < 8; i++) load(8'($urandom));
    en = 1'b1; out_ready = 1'b1;
    wait_xfers(2, "endrop_first");
    en = 1'b0;
    for (int i = 0; i < 50 && busy; i++) tick();
    checks++;
    if (busy !== 1'b0 || exp_frames != 1 || data_xfers != 4 || frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL endrop_finish: busy=%b frames=%0d words=%0d cnt=%0d, required 0/1/4/1",
               busy, exp_frames, data_xfers, frame_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (r_en !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL endrop_idle%0d: r_en=%b busy=%b, required 0/0", i, r_en, busy);
      end
    end
    en = 1'b1;
    wait_frames(2, "endrop_restart");
    checks++;
    if (frame_cnt !== 16'd2) begin
      errors++; $display("FAIL endrop_frame_cnt: %0d, required 2", frame_cnt);
    end
  endtask

  task automatic test_random();
    int loaded = 0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 1500 && exp_frames < 8; i++) begin
      if (loaded < 32 && $urandom_range(0, 2) != 0) begin
        load(8'($urandom)); loaded++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    checks++;
    if (exp_frames != 8 || frame_cnt !== 16'd8) begin
      errors++; $display("FAIL random_frames: model=%0d dut=%0d, required 8", exp_frames, frame_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 12; i++) load(8'($urandom));
    en = 1'b1; out_ready = 1'b1;
    wait_xfers(6, "rmid_first");
    rrst_n = 1'b0;
    #1;
    checks++;
    if ({r_en, out_valid, out_last, busy} !== 4'b0000 || out_data !== 8'h00 || frame_cnt !== 16'h0) begin
      errors++;
      $display("FAIL rmid_async: r_en=%b valid=%b last=%b busy=%b data=%h frames=%0d, required all 0",
               r_en, out_valid, out_last, busy, out_data, frame_cnt);
    end
    @(posedge rclk); #1;
    tick();
    rrst_n = 1'b1;
    for (int i = 0; i < 4; i++) load(8'($urandom));
    wait_frames(1, "rmid");
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++; $display("FAIL rmid_frame_cnt: %0d, required 1", frame_cnt);
    end
  endtask

  task automatic test_wrap();
    en_w = 1'b1; out_ready_w = 1'b1;
    for (int i = 0; i < 400 && w_frames < 16; i++) tick();
    checks++;
    if (w_frames != 16 || frame_cnt_w !== 4'd0) begin
      errors++; $display("FAIL wrap_16: frames=%0d cnt=%0d, required 16/0", w_frames, frame_cnt_w);
    end
    en_w = 1'b0;
    for (int i = 0; i < 50 && busy_w; i++) tick();
    checks++;
    if (w_frames != 17 || frame_cnt_w !== 4'd1 || busy_w !== 1'b0) begin
      errors++;
      $display("FAIL wrap_17: frames=%0d cnt=%0d busy=%b, required 17/1/0", w_frames, frame_cnt_w, busy_w);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_underflow();
    test_en_drop();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
